spi_master: RTL and testbench

Mode-0 SPI master for the FPGA side of the STM32–FPGA link, the initiator counterpart of `spi_slave`. It serialises bytes presented on a valid/ready interface onto `mosi` and, full-duplex, deserialises `miso` into `rx_data`. Back-to-back bytes share one chip-select assertion. It sits between fabric logic and the board pins, for driving an MCU or peripheral configured as SPI slave.

---
 rtl/spi_master.sv | 137 +++++++++++++
 tb/tb_spi_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master: valid/ready byte input, full-duplex shift, burst under one chip select.
module spi_master #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    tx_sr, tx_sr_d;
  logic [7:0]    rx_sr, rx_sr_d;
  logic [7:0]    rx_data_d;
  logic          rx_valid_d;
  logic          sclk_d, cs_d, mosi_d;
  logic          cnt_zero_c;
  logic          accept_c;

  assign cnt_zero_c = (cnt == '0);
  // Ready in IDLE or in the final HOLD cycle so a burst keeps cs low.
  assign tx_ready   = (state == IDLE) || ((state == HOLD) && cnt_zero_c);
  assign accept_c   = tx_valid && tx_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (accept_c) state_d = SETUP;
      SETUP: if (cnt_zero_c) state_d = XFER;
      XFER:  if (cnt_zero_c && sclk && (bit_cnt == 3'd7)) state_d = HOLD;
      HOLD:  if (cnt_zero_c) state_d = accept_c ? SETUP : GAP;
      GAP:   if (cnt_zero_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d      = (state == IDLE || cnt_zero_c) ? RELOAD : cnt - CW'(1);
    bit_cnt_d  = bit_cnt;
    tx_sr_d    = tx_sr;
    rx_sr_d    = rx_sr;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    sclk_d     = sclk;
    cs_d       = cs;
    mosi_d     = mosi;

    if (accept_c) begin
      tx_sr_d   = tx_data;
      mosi_d    = tx_data[7];
      cs_d      = 1'b0;
      bit_cnt_d = 3'd0;
    end

    unique case (state)
      SETUP: begin
        if (cnt_zero_c) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr[6:0], miso};
        end
      end
      XFER: begin
        if (cnt_zero_c) begin
          if (!sclk) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr[6:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == 3'd7) begin
              rx_data_d  = rx_sr;
              rx_valid_d = 1'b1;
            end else begin
              tx_sr_d   = {tx_sr[6:0], 1'b0};
              mosi_d    = tx_sr[6];
              bit_cnt_d = bit_cnt + 3'd1;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_zero_c && !accept_c) cs_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= RELOAD;
      bit_cnt  <= 3'd0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_sr    <= tx_sr_d;
      rx_sr    <= rx_sr_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      sclk     <= sclk_d;
      cs       <= cs_d;
      mosi     <= mosi_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with H=2 (slave model) and H=1 (loopback) instances.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // H=2 instance
  logic [7:0] tx_data0 = 8'h00;
  logic       tx_valid0 = 1'b0;
  logic       tx_ready0;
  logic [7:0] rx_data0;
  logic       rx_valid0, busy0, sclk0, cs0, mosi0;
  logic       miso0 = 1'b0;

  // H=1 instance
  logic [7:0] tx_data1 = 8'h00;
  logic       tx_valid1 = 1'b0;
  logic       tx_ready1;
  logic [7:0] rx_data1;
  logic       rx_valid1, busy1, sclk1, cs1, mosi1;

  spi_master #(.CLK_DIV(2)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0), .sclk(sclk0), .cs(cs0),
    .mosi(mosi0), .miso(miso0)
  );

  spi_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .cs(cs1),
    .mosi(mosi1), .miso(mosi1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model for u0: loads a response byte when cs falls and after every 8th falling sclk.
  logic [7:0] slave_q[$];
  logic [7:0] sreg = 8'h00;
  int         sbit = 0;
  bit         sact = 0;
  always @(cs0 or negedge sclk0) begin
    if (cs0) begin
      sact = 0;
      sbit = 0;
    end else if (!sact) begin
      sact = 1;
      sbit = 0;
      sreg = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
      miso0 = sreg[7];
    end else if (!sclk0) begin
      sbit++;
      if (sbit == 8) begin
        sbit = 0;
        sreg = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
      end else begin
        sreg = {sreg[6:0], 1'b0};
      end
      miso0 = sreg[7];
    end
  end

  // Capture mosi bytes at rising sclk on u0.
  logic [7:0] mosi_q[$];
  logic [7:0] rb = 8'h00;
  int         rn = 0;
  always @(posedge sclk0 or negedge cs0) begin
    if (sclk0) begin
      rb = {rb[6:0], mosi0};
      rn++;
      if (rn % 8 == 0) mosi_q.push_back(rb);
    end else begin
      rn = 0;
    end
  end

  int rise1 = 0;
  always @(posedge sclk1) rise1++;

  // Per-cycle observation of u0.
  int         cyc;
  int         idle_cyc;
  int         cs_low_n;
  int         acc_cyc[$];
  int         rv_cyc[$];
  logic [7:0] rx_q[$];
  logic [7:0] tx_pend[$];

  task automatic clear_obs();
    cyc = 0;
    idle_cyc = -1;
    cs_low_n = 0;
    acc_cyc.delete();
    rv_cyc.delete();
    rx_q.delete();
    mosi_q.delete();
  endtask

  task automatic step();
    logic pre;
    pre = tx_valid0 && tx_ready0;
    @(posedge clk);
    #1;
    cyc++;
    if (pre) begin
      acc_cyc.push_back(cyc);
      if (tx_pend.size() > 0) tx_data0 = tx_pend.pop_front();
      else tx_valid0 = 1'b0;
    end
    if (rx_valid0) begin
      rv_cyc.push_back(cyc);
      rx_q.push_back(rx_data0);
    end
    if (!cs0) cs_low_n++;
    if (!busy0 && idle_cyc < 0 && acc_cyc.size() > 0 && !pre) idle_cyc = cyc;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_rx_data", rx_data0, 8'h00);
    chk("rst_rx_valid", rx_valid0, 0);
    chk("rst_busy", busy0, 0);
    rst = 1'b0;

    // Idle for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("idle_cs", cs0, 1);
      chk("idle_sclk", sclk0, 0);
      chk("idle_busy", busy0, 0);
      chk("idle_tx_ready", tx_ready0, 1);
    end

    // Single byte 0xA5, slave returns 0x3C
    clear_obs();
    slave_q.push_back(8'h3C);
    tx_data0 = 8'hA5;
    tx_valid0 = 1'b1;
    step();
    chk("t1_cs_at_e0", cs0, 0);
    chk("t1_mosi_bit7", mosi0, 1);
    repeat (39) step();
    chk("t1_accepts", acc_cyc.size(), 1);
    chk("t1_mosi_byte", mosi_q[0], 8'hA5);
    chk("t1_rv_count", rv_cyc.size(), 1);
    chk("t1_rv_time", rv_cyc[0] - acc_cyc[0], 32);
    chk("t1_rx_data", rx_q[0], 8'h3C);
    chk("t1_cs_low", cs_low_n, 34);
    chk("t1_idle_time", idle_cyc - acc_cyc[0], 36);

    // Burst 0x01, 0x80, 0xFF
    clear_obs();
    slave_q.push_back(8'hFE);
    slave_q.push_back(8'h7F);
    slave_q.push_back(8'h5C);
    tx_pend.push_back(8'h80);
    tx_pend.push_back(8'hFF);
    tx_data0 = 8'h01;
    tx_valid0 = 1'b1;
    repeat (120) step();
    chk("b_accepts", acc_cyc.size(), 3);
    chk("b_space01", acc_cyc[1] - acc_cyc[0], 34);
    chk("b_space12", acc_cyc[2] - acc_cyc[1], 34);
    chk("b_rv_count", rv_cyc.size(), 3);
    chk("b_rx0", rx_q[0], 8'hFE);
    chk("b_rx1", rx_q[1], 8'h7F);
    chk("b_rx2", rx_q[2], 8'h5C);
    chk("b_mosi0", mosi_q[0], 8'h01);
    chk("b_mosi1", mosi_q[1], 8'h80);
    chk("b_mosi2", mosi_q[2], 8'hFF);
    chk("b_cs_low", cs_low_n, 102);
    chk("b_idle_time", idle_cyc - acc_cyc[2], 36);

    // Reset mid-byte at E0+7
    clear_obs();
    slave_q.push_back(8'h99);
    tx_data0 = 8'h77;
    tx_valid0 = 1'b1;
    step();
    repeat (7) step();
    chk("r_busy_before", busy0, 1);
    rst = 1'b1;
    #1;
    chk("r_cs", cs0, 1);
    chk("r_sclk", sclk0, 0);
    chk("r_mosi", mosi0, 0);
    chk("r_busy", busy0, 0);
    chk("r_rx_valid", rx_valid0, 0);
    chk("r_rx_data", rx_data0, 8'h00);
    chk("r_tx_ready", tx_ready0, 1);
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    chk("r_no_rv", rv_cyc.size(), 0);

    // Clean transfer after reset
    clear_obs();
    slave_q.push_back(8'hA5);
    tx_data0 = 8'h5A;
    tx_valid0 = 1'b1;
    repeat (40) step();
    chk("r2_mosi_byte", mosi_q[0], 8'h5A);
    chk("r2_rv_count", rv_cyc.size(), 1);
    chk("r2_rx_data", rx_q[0], 8'hA5);

    // tx_data changed while waiting; only the value at the HOLD accept is sent
    clear_obs();
    slave_q.push_back(8'h00);
    slave_q.push_back(8'h00);
    tx_data0 = 8'h3C;
    tx_valid0 = 1'b1;
    step();
    repeat (9) step();
    tx_valid0 = 1'b1;
    tx_data0 = 8'h11;
    repeat (10) step();
    tx_data0 = 8'h22;
    repeat (10) step();
    tx_data0 = 8'h96;
    repeat (60) step();
    chk("d_accepts", acc_cyc.size(), 2);
    chk("d_accept_time", acc_cyc[1] - acc_cyc[0], 34);
    chk("d_mosi0", mosi_q[0], 8'h3C);
    chk("d_mosi1", mosi_q[1], 8'h96);
    chk("d_rv_count", rv_cyc.size(), 2);

    // H=1 transfer of 0xC3 with loopback
    tx_data1 = 8'hC3;
    tx_valid1 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid1 = 1'b0;
    chk("h1_cs_at_e0", cs1, 0);
    chk("h1_mosi_bit7", mosi1, 1);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      chk("h1_sclk", sclk1, (k <= 16) ? (k % 2) : 0);
      chk("h1_rx_valid", rx_valid1, (k == 16) ? 1 : 0);
      chk("h1_cs", cs1, (k >= 17) ? 1 : 0);
      chk("h1_tx_ready", tx_ready1, (k == 16 || k >= 18) ? 1 : 0);
      chk("h1_busy", busy1, (k < 18) ? 1 : 0);
    end
    chk("h1_rises", rise1, 8);
    chk("h1_rx_data", rx_data1, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
